// File: rtl/mips_pkg.sv
// Shared MIPS core constants: reset/exception vectors, CP0 exception codes,
// legal fetch window, and the F/D stage payload type.
package mips_pkg;

  localparam logic [31:0] RESET_PC = 32'h0000_3000;
  localparam logic [31:0] EBASE    = 32'h0000_4180;

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  localparam logic [31:0] INSTR_LO = 32'h0000_3000;
  localparam logic [31:0] INSTR_HI = 32'h0000_6ffc;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [4:0]  exccode;
    logic        bd;
    logic        valid;
  } fd_dat_t;

endpackage

// File: rtl/fd_perf_cnt.sv
// Stall and flush event counters for the F/D register; 32-bit, wrap on overflow.
// Latency: counts visible one cycle after the event edge.
// Backpressure: none; pure observer of the hazard controls.
module fd_perf_cnt (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        req,
  input  logic        eret_D,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
);

  logic stall_inc;
  logic flush_inc;

  // req outranks a stall, so a stalled req edge counts only as a flush.
  assign stall_inc = !req && !en;
  assign flush_inc = req || (en && eret_D);

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_inc) stall_cnt <= stall_cnt + 32'd1;
      if (flush_inc) flush_cnt <= flush_cnt + 32'd1;
    end
  end

endmodule

// File: rtl/fd_reg.sv
// F/D pipeline register with stall, exception flush and eret squash; FD_PERF_CNT_EN adds counters.
// Latency: one cycle F to D, all outputs registered.
// Backpressure: en=0 holds every D output; req flushes even while stalled.
module fd_reg #(
  parameter logic [31:0] RESET_PC = mips_pkg::RESET_PC,
  parameter logic [31:0] EBASE    = mips_pkg::EBASE,
  parameter logic [4:0]  EXC_ADEL = mips_pkg::EXC_ADEL
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        req,
  input  logic        eret_D,
  input  logic [31:0] F_pc,
  input  logic [31:0] F_instr,
  input  logic        F_AdEL,
  input  logic        F_bd,
  output logic [31:0] D_pc,
  output logic [31:0] D_instr,
  output logic [4:0]  D_exccode,
  output logic        D_bd,
  output logic        D_valid,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
);
  import mips_pkg::*;

  fd_dat_t d_q;
  fd_dat_t d_nxt;

  // Bubbles keep a real pc so CP0 can still derive EPC downstream.
  always_comb begin
    d_nxt = d_q;
    if (req) begin
      d_nxt = '{pc: EBASE, instr: 32'h0, exccode: 5'd0, bd: 1'b0, valid: 1'b0};
    end else if (!en) begin
      d_nxt = d_q;
    end else if (eret_D) begin
      d_nxt = '{pc: F_pc, instr: 32'h0, exccode: 5'd0, bd: 1'b0, valid: 1'b0};
    end else begin
      d_nxt.pc      = F_pc;
      d_nxt.instr   = F_AdEL ? 32'h0 : F_instr;
      d_nxt.exccode = F_AdEL ? EXC_ADEL : 5'd0;
      d_nxt.bd      = F_bd;
      d_nxt.valid   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      d_q <= '{pc: RESET_PC, instr: 32'h0, exccode: 5'd0, bd: 1'b0, valid: 1'b0};
    end else begin
      d_q <= d_nxt;
    end
  end

  assign D_pc      = d_q.pc;
  assign D_instr   = d_q.instr;
  assign D_exccode = d_q.exccode;
  assign D_bd      = d_q.bd;
  assign D_valid   = d_q.valid;

`ifdef FD_PERF_CNT_EN
  fd_perf_cnt u_perf_cnt (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .req       (req),
    .eret_D    (eret_D),
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
  );
`else
  assign stall_cnt = 32'd0;
  assign flush_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_fd_reg.sv
// Scoreboard bench for fd_reg: directed vectors push hand-computed D-stage
// results; a monitor pops and compares one entry after every rising edge.
module tb_fd_reg;

  logic        clk = 1'b0;
  logic        reset, en, req, eret_D, F_AdEL, F_bd;
  logic [31:0] F_pc, F_instr;
  logic [31:0] D_pc, D_instr, stall_cnt, flush_cnt;
  logic [4:0]  D_exccode;
  logic        D_bd, D_valid;

  int checks   = 0;
  int failures = 0;

`ifdef FD_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  fd_reg dut (
    .clk(clk), .reset(reset), .en(en), .req(req), .eret_D(eret_D),
    .F_pc(F_pc), .F_instr(F_instr), .F_AdEL(F_AdEL), .F_bd(F_bd),
    .D_pc(D_pc), .D_instr(D_instr), .D_exccode(D_exccode), .D_bd(D_bd),
    .D_valid(D_valid), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          rst, rq, e, er, adel, bd;
    logic [31:0] pc, instr;
    logic [31:0] x_pc, x_instr;
    logic [4:0]  x_exc;
    bit          x_bd, x_valid;
    int unsigned x_stall, x_flush;
  } vec_t;

  typedef struct {
    int          idx;
    logic [31:0] pc, instr, stall, flush;
    logic [4:0]  exc;
    logic        bd, valid;
  } exp_t;

  exp_t sb_q[$];
  vec_t vecs[$];

  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s vec=%0d got=%h want=%h", name, idx, act, exp);
    end
  endtask

  // Monitor: D outputs are presented every cycle, so one entry retires per edge.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        x = sb_q.pop_front();
        check("D_pc",      x.idx, D_pc,             x.pc);
        check("D_instr",   x.idx, D_instr,          x.instr);
        check("D_exccode", x.idx, {27'd0, D_exccode}, {27'd0, x.exc});
        check("D_bd",      x.idx, {31'd0, D_bd},    {31'd0, x.bd});
        check("D_valid",   x.idx, {31'd0, D_valid}, {31'd0, x.valid});
        check("stall_cnt", x.idx, stall_cnt,        x.stall);
        check("flush_cnt", x.idx, flush_cnt,        x.flush);
      end
    end
  end

  function automatic vec_t mk(bit rst, bit rq, bit e, bit er, logic [31:0] pc, logic [31:0] instr,
                              bit adel, bit bd, logic [31:0] x_pc, logic [31:0] x_instr,
                              logic [4:0] x_exc, bit x_bd, bit x_valid,
                              int unsigned x_stall, int unsigned x_flush);
    vec_t v;
    v.rst = rst; v.rq = rq; v.e = e; v.er = er; v.pc = pc; v.instr = instr;
    v.adel = adel; v.bd = bd; v.x_pc = x_pc; v.x_instr = x_instr; v.x_exc = x_exc;
    v.x_bd = x_bd; v.x_valid = x_valid; v.x_stall = x_stall; v.x_flush = x_flush;
    return v;
  endfunction

  initial begin
    exp_t x;
    int   guard;
    reset = 1'b1; en = 1'b0; req = 1'b0; eret_D = 1'b0;
    F_pc = 32'h0; F_instr = 32'h0; F_AdEL = 1'b0; F_bd = 1'b0;

    //             rst rq en er  F_pc          F_instr       adel bd  D_pc          D_instr       exc bd v  stall flush
    vecs.push_back(mk(1, 0, 1, 0, 32'h0000_1234, 32'hffff_ffff, 0, 1, 32'h0000_3000, 32'h0,        0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 32'h0000_1234, 32'hffff_ffff, 0, 0, 32'h0000_3000, 32'h0,        0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 32'h0000_3000, 32'h3c01_0001, 0, 0, 32'h0000_3000, 32'h3c01_0001, 0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0000_3004, 32'h3421_0002, 0, 0, 32'h0000_3000, 32'h3c01_0001, 0, 0, 1, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0000_3008, 32'h0000_0000, 0, 1, 32'h0000_3000, 32'h3c01_0001, 0, 0, 1, 2, 0));
    vecs.push_back(mk(0, 0, 0, 1, 32'h0000_3008, 32'h0000_0000, 1, 0, 32'h0000_3000, 32'h3c01_0001, 0, 0, 1, 3, 0));
    vecs.push_back(mk(0, 1, 0, 0, 32'h0000_3008, 32'h1111_1111, 0, 1, 32'h0000_4180, 32'h0,        0, 0, 0, 3, 1));
    vecs.push_back(mk(0, 1, 1, 0, 32'h0000_3010, 32'h2222_2222, 0, 1, 32'h0000_4180, 32'h0,        0, 0, 0, 3, 2));
    vecs.push_back(mk(0, 0, 1, 0, 32'h0000_3002, 32'hdead_beef, 1, 0, 32'h0000_3002, 32'h0,        4, 0, 1, 3, 2));
    vecs.push_back(mk(0, 0, 1, 0, 32'h0000_3004, 32'h2402_0005, 0, 1, 32'h0000_3004, 32'h2402_0005, 0, 1, 1, 3, 2));
    vecs.push_back(mk(0, 0, 1, 1, 32'h0000_300c, 32'h1111_1111, 1, 1, 32'h0000_300c, 32'h0,        0, 0, 0, 3, 3));
    vecs.push_back(mk(0, 0, 1, 0, 32'h0000_3008, 32'h8c03_0000, 0, 0, 32'h0000_3008, 32'h8c03_0000, 0, 0, 1, 3, 3));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0000_300c, 32'h0000_0000, 0, 1, 32'h0000_3008, 32'h8c03_0000, 0, 0, 1, 4, 3));
    vecs.push_back(mk(0, 1, 1, 1, 32'h0000_3010, 32'h3333_3333, 0, 1, 32'h0000_4180, 32'h0,        0, 0, 0, 4, 4));
    vecs.push_back(mk(0, 0, 1, 0, 32'h0000_3010, 32'h0043_0820, 0, 1, 32'h0000_3010, 32'h0043_0820, 0, 1, 1, 4, 4));
    vecs.push_back(mk(1, 1, 0, 1, 32'h0000_3014, 32'h4444_4444, 1, 1, 32'h0000_3000, 32'h0,        0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 32'h0000_3014, 32'h1234_5678, 0, 0, 32'h0000_3014, 32'h1234_5678, 0, 0, 1, 0, 0));

    foreach (vecs[i]) begin
      @(negedge clk);
      reset = vecs[i].rst; req = vecs[i].rq; en = vecs[i].e; eret_D = vecs[i].er;
      F_pc = vecs[i].pc; F_instr = vecs[i].instr; F_AdEL = vecs[i].adel; F_bd = vecs[i].bd;
      x.idx = i; x.pc = vecs[i].x_pc; x.instr = vecs[i].x_instr; x.exc = vecs[i].x_exc;
      x.bd = vecs[i].x_bd; x.valid = vecs[i].x_valid;
      x.stall = PERF ? 32'(vecs[i].x_stall) : 32'd0;
      x.flush = PERF ? 32'(vecs[i].x_flush) : 32'd0;
      sb_q.push_back(x);
    end

    guard = 0;
    while (sb_q.size() > 0 && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL drain left=%0d want=0", sb_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout checks=%0d", checks);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "timeout");
  end

endmodule
